// File: rtl/ising_ctrl_pkg.sv
// Shared definitions for the Ising array run sequencer: register indices,
// CTRL bit positions and the sequencer state encoding.
package ising_ctrl_pkg;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_RUN_CYCLES = 3'd1;
    localparam logic [2:0] REG_STATUS     = 3'd2;
    localparam logic [2:0] REG_SAMPLE     = 3'd3;
    localparam logic [2:0] REG_ELAPSED    = 3'd4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_CLR_DONE = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } run_state_e;

endpackage

// File: rtl/spin_sync.sv
// Multi-stage synchroniser bringing the asynchronous cell outputs into clk.
module spin_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled spin-cell array: settle, timed free run,
// synchronised capture of the final spins, with a small register interface.
module ising_run_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter int NUM_SPINS     = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 axi_rst,
    input  logic                 wready,
    input  logic [2:0]           waddr,
    input  logic [31:0]          wdata,
    input  logic [2:0]           raddr,
    output logic [31:0]          rdata,
    input  logic [NUM_SPINS-1:0] spin_in,
    output logic                 ising_rstn,
    output logic                 cfg_lock,
    output logic                 done_irq
);

    localparam logic [CNT_W-1:0] PH_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PH_SYNC   = CNT_W'(SYNC_STAGES - 1);

    run_state_e           state_q, state_d;
    logic [CNT_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]     elapsed_q, elapsed_d;
    logic [CNT_W-1:0]     run_cycles_q;
    logic [CNT_W-1:0]     run_last;
    logic [NUM_SPINS-1:0] sample_q, sample_d;
    logic [NUM_SPINS-1:0] spin_sync_q;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 rstn_q;
    logic                 busy;
    logic                 ctrl_wr, start_req, abort_req, clr_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    spin_sync #(
        .WIDTH (NUM_SPINS),
        .STAGES(SYNC_STAGES)
    ) u_spin_sync (
        .clk(clk),
        .rst(axi_rst),
        .d  (spin_in),
        .q  (spin_sync_q)
    );

    assign busy      = (state_q != ST_IDLE);
    assign ctrl_wr   = wready && (waddr == REG_CTRL);
    assign abort_req = ctrl_wr && wdata[CTRL_ABORT];
    assign start_req = ctrl_wr && wdata[CTRL_START] && !wdata[CTRL_ABORT];
    assign clr_req   = ctrl_wr && wdata[CTRL_CLR_DONE];
    // A programmed length of zero still runs for one cycle.
    assign run_last  = (run_cycles_q == '0) ? '0 : run_cycles_q - CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        elapsed_d = elapsed_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        sample_d  = sample_q;
        if (clr_req) done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d   = ST_SETTLE;
                    phase_d   = PH_SETTLE;
                    elapsed_d = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (phase_q == '0) state_d = ST_RUN;
                else               phase_d = phase_q - CNT_W'(1);
            end
            ST_RUN: begin
                elapsed_d = sat_inc(elapsed_q);
                if (elapsed_q == run_last) begin
                    state_d = ST_CAPTURE;
                    phase_d = PH_SYNC;
                end
            end
            ST_CAPTURE: begin
                if (phase_q == '0) begin
                    state_d  = ST_IDLE;
                    sample_d = spin_sync_q;
                    done_d   = 1'b1;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides whatever the busy state would have done this edge.
        if (abort_req && busy) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
            sample_d  = sample_q;
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            elapsed_q    <= '0;
            run_cycles_q <= '0;
            sample_q     <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            rstn_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            elapsed_q <= elapsed_d;
            sample_q  <= sample_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            rstn_q    <= (state_d == ST_RUN) || (state_d == ST_CAPTURE);
            if (wready && (waddr == REG_RUN_CYCLES) && !busy)
                run_cycles_q <= wdata[CNT_W-1:0];
        end
    end

    assign ising_rstn = rstn_q;
    assign cfg_lock   = busy;
    assign done_irq   = done_q;

    always_comb begin
        rdata = '0;
        case (raddr)
            REG_RUN_CYCLES: rdata = 32'(run_cycles_q);
            REG_STATUS:     rdata = {26'd0, state_q, 1'b0, aborted_q, done_q, busy};
            REG_SAMPLE:     rdata = 32'(sample_q);
            REG_ELAPSED:    rdata = 32'(elapsed_q);
            default:        rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: register table plus hand-written run sequences.
module tb_ising_run_ctrl;
    import ising_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        wready = 1'b0;
    logic [2:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  raddr = '0;
    logic [31:0] rdata;
    logic [31:0] spin_in = 32'hA5A5_0F0F;
    logic        ising_rstn, cfg_lock, done_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ising_run_ctrl #(
        .NUM_SPINS(32), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .CNT_W(32)
    ) dut (
        .clk(clk), .axi_rst(axi_rst), .wready(wready), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .spin_in(spin_in), .ising_rstn(ising_rstn),
        .cfg_lock(cfg_lock), .done_irq(done_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wready = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        wready = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
        raddr = a; #1; v = rdata;
    endtask

    task automatic wait_rstn(input logic v, input string nm);
        int n = 0;
        while (ising_rstn !== v && n < 200) begin step(); n++; end
        chk(nm, 32'(ising_rstn), 32'(v));
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        logic [31:0] st;
        int n = 0;
        rd_reg(REG_STATUS, st);
        while (st[5:4] !== s && n < 200) begin step(); rd_reg(REG_STATUS, st); n++; end
        chk(nm, 32'(st[5:4]), 32'(s));
    endtask

    // Counts low then high cycles of ising_rstn starting right after a START write.
    task automatic measure_run(output int lows, output int highs);
        int n = 0;
        lows = 0; highs = 0;
        while (n < 300) begin
            if (!ising_rstn && highs == 0) lows++;
            else if (ising_rstn) highs++;
            else break;
            step(); n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int lows, highs, t0, t1;

        vecs[0] = '{0, 3'd0, 32'h0, REG_CTRL,       32'h0, "rst_ctrl"};
        vecs[1] = '{0, 3'd0, 32'h0, REG_RUN_CYCLES, 32'h0, "rst_run_cycles"};
        vecs[2] = '{0, 3'd0, 32'h0, REG_STATUS,     32'h0, "rst_status"};
        vecs[3] = '{0, 3'd0, 32'h0, REG_SAMPLE,     32'h0, "rst_sample"};
        vecs[4] = '{0, 3'd0, 32'h0, REG_ELAPSED,    32'h0, "rst_elapsed"};
        vecs[5] = '{1, REG_RUN_CYCLES, 32'd10, REG_RUN_CYCLES, 32'd10, "run_cycles_rw"};
        vecs[6] = '{1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0, "unmapped_read"};
        vecs[7] = '{1, 3'd7, 32'd1, REG_RUN_CYCLES, 32'd10, "unmapped_write_ignored"};
        vecs[8] = '{1, REG_CTRL, 32'h4, REG_CTRL, 32'h0, "ctrl_reads_zero"};
        vecs[9] = '{1, REG_CTRL, 32'h2, REG_STATUS, 32'h0, "abort_in_idle"};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ising_rstn", 32'(ising_rstn), 32'd0);
        chk("rst_done_irq",   32'(done_irq),   32'd0);
        chk("rst_cfg_lock",   32'(cfg_lock),   32'd0);
        @(negedge clk); axi_rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) wr_reg(vecs[i].wa, vecs[i].wd);
            rd_reg(vecs[i].ra, v);
            chk(vecs[i].name, v, vecs[i].exp);
        end

        // Basic run, length 10
        wr_reg(REG_CTRL, 32'h1);
        chk("basic_cfg_lock", 32'(cfg_lock), 32'd1);
        rd_reg(REG_STATUS, v);
        chk("basic_status_settle", v, 32'h11);
        measure_run(lows, highs);
        chk("basic_settle_len", 32'(lows),  32'd4);
        chk("basic_high_len",   32'(highs), 32'd12);
        chk("basic_done_irq",   32'(done_irq), 32'd1);
        rd_reg(REG_SAMPLE, v);  chk("basic_sample",  v, 32'hA5A5_0F0F);
        rd_reg(REG_ELAPSED, v); chk("basic_elapsed", v, 32'd10);
        rd_reg(REG_STATUS, v);  chk("basic_status_done", v, 32'h2);

        // Zero length run
        wr_reg(REG_RUN_CYCLES, 32'd0);
        wr_reg(REG_CTRL, 32'h1);
        chk("zero_done_cleared", 32'(done_irq), 32'd0);
        rd_reg(REG_ELAPSED, v); chk("zero_elapsed_cleared", v, 32'd0);
        measure_run(lows, highs);
        chk("zero_high_len", 32'(highs), 32'd3);
        rd_reg(REG_ELAPSED, v); chk("zero_elapsed", v, 32'd1);
        chk("zero_done_irq", 32'(done_irq), 32'd1);

        // Abort on the 5th RUN cycle; SAMPLE must keep the previous capture
        wr_reg(REG_RUN_CYCLES, 32'd10);
        spin_in = 32'h1234_5678;
        wr_reg(REG_CTRL, 32'h1);
        wait_state(2'd2, "abort_reach_run");
        repeat (4) step();
        wr_reg(REG_CTRL, 32'h2);
        chk("abort_rstn",     32'(ising_rstn), 32'd0);
        chk("abort_done_irq", 32'(done_irq),   32'd0);
        chk("abort_cfg_lock", 32'(cfg_lock),   32'd0);
        rd_reg(REG_STATUS, v); chk("abort_status", v, 32'h4);
        rd_reg(REG_SAMPLE, v); chk("abort_sample_kept", v, 32'hA5A5_0F0F);

        // START and RUN_CYCLES writes while busy are ignored
        wr_reg(REG_RUN_CYCLES, 32'd6);
        wr_reg(REG_CTRL, 32'h1);
        rd_reg(REG_STATUS, v); chk("restart_aborted_clr", v, 32'h11);
        wait_rstn(1'b1, "coll_enter_run");
        t0 = cyc;
        wr_reg(REG_CTRL, 32'h1);
        wr_reg(REG_RUN_CYCLES, 32'd99);
        wait_rstn(1'b0, "coll_end_run");
        t1 = cyc;
        chk("coll_high_len", 32'(t1 - t0), 32'd8);
        rd_reg(REG_RUN_CYCLES, v); chk("coll_run_cycles", v, 32'd6);
        rd_reg(REG_ELAPSED, v);    chk("coll_elapsed", v, 32'd6);
        rd_reg(REG_SAMPLE, v);     chk("coll_sample", v, 32'h1234_5678);

        // START+ABORT from IDLE: nothing happens, done stays set
        wr_reg(REG_CTRL, 32'h3);
        rd_reg(REG_STATUS, v); chk("start_abort_idle", v, 32'h2);
        step();
        chk("start_abort_rstn", 32'(ising_rstn), 32'd0);

        // spin_in toggled one cycle before the capture edge is not seen
        spin_in = 32'hA5A5_0F0F;
        wr_reg(REG_RUN_CYCLES, 32'd3);
        wr_reg(REG_CTRL, 32'h1);
        wait_state(2'd3, "late_reach_capture");
        step();
        spin_in[0] = 1'b0;
        wait_rstn(1'b0, "late_end");
        rd_reg(REG_SAMPLE, v); chk("late_sample", v, 32'hA5A5_0F0F);
        chk("late_done_irq", 32'(done_irq), 32'd1);
        wr_reg(REG_CTRL, 32'h4);
        chk("clr_done_irq", 32'(done_irq), 32'd0);
        rd_reg(REG_STATUS, v); chk("clr_status", v, 32'h0);

        // Asynchronous reset mid-run
        wr_reg(REG_CTRL, 32'h1);
        wait_rstn(1'b1, "arst_enter_run");
        #2 axi_rst = 1'b1;
        #1;
        chk("arst_rstn",    32'(ising_rstn), 32'd0);
        chk("arst_lock",    32'(cfg_lock),   32'd0);
        rd_reg(REG_RUN_CYCLES, v); chk("arst_run_cycles", v, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ising_run_ctrl.md
Name: ising_run_ctrl

Overview:
- Run sequencer for the coupled spin-cell array. Owns the global ising_rstn, the release of the array from its loaded start spins, run-length timing and the capture of final spin states.
- Sits beside the per-cell spin-load registers on the same clk/AXI write bus.
- Software programs a run length, writes START, polls or waits on done_irq, then reads the synchronised spin snapshot.

Parameters:
- NUM_SPINS, 32: number of cell outputs sampled; 1..32, returned in SAMPLE[NUM_SPINS-1:0].
- SETTLE_CYCLES, 4: cycles ising_rstn is held low after START so loaded spins propagate; must be >= 1.
- SYNC_STAGES, 2: flop stages on spin_in before capture; must be >= 2.
- CNT_W, 32: width of the run-length and elapsed counters.

Ports:
- clk  in  1  system/AXI clock
- axi_rst  in  1  asynchronous, active-high reset
- wready  in  1  write strobe, single-cycle
- waddr  in  3  register index
- wdata  in  32  write data
- raddr  in  3  read register index
- rdata  out  32  combinational read data for raddr
- spin_in  in  NUM_SPINS  asynchronous cell outputs (tout/rout of each cell)
- ising_rstn  out  1  registered; 0 = cells forced to loaded spin, 1 = free-running
- cfg_lock  out  1  1 while busy; spin-load writes to cells must be gated by the top level
- done_irq  out  1  level interrupt, sticky until cleared

Behaviour:
- Register map (index), sticky fields cleared only as stated:
  - 0 CTRL (W): bit0 START, bit1 ABORT, bit2 CLR_DONE. Self-clearing; reads 0.
  - 1 RUN_CYCLES (R/W): CNT_W bits.
  - 2 STATUS (R): bit0 busy, bit1 done, bit2 aborted, bits[5:4] state encoding.
  - 3 SAMPLE (R): captured spins, zero-extended.
  - 4 ELAPSED (R): RUN cycles completed in the last or current run.
  - Other indices read 0; writes to them are ignored.
- Reset (axi_rst=1, async):
  - state IDLE; ising_rstn=0, cfg_lock=0, done_irq=0.
  - RUN_CYCLES=0, SAMPLE=0, ELAPSED=0, aborted=0.
  - All sync flops 0.
- States and encoding: IDLE=0, SETTLE=1, RUN=2, CAPTURE=3. DONE is IDLE with done=1.
- START accepted only in IDLE. Write on edge N means:
  - SETTLE from N+1; ising_rstn stays 0 for SETTLE_CYCLES cycles.
  - done, done_irq, aborted and ELAPSED all clear on acceptance.
- RUN:
  - ising_rstn=1 from the first RUN cycle.
  - Lasts max(RUN_CYCLES,1) cycles; RUN_CYCLES=0 is treated as 1.
  - ELAPSED increments each RUN cycle and saturates at all-ones.
- CAPTURE:
  - ising_rstn stays 1 for SYNC_STAGES cycles so the synchroniser holds the end-of-run value.
  - On the final CAPTURE edge, SAMPLE <= synchronised spin_in, and state becomes IDLE with ising_rstn=0, done=1, done_irq=1.
- busy = cfg_lock = (state != IDLE).
- START while busy is ignored, with no effect on counters.
- RUN_CYCLES writes while busy are ignored; the value latched at START is used.
- ABORT in any busy state: next edge goes to IDLE with ising_rstn=0, aborted=1, done=0, SAMPLE unchanged. ABORT in IDLE has no effect.
- START and ABORT in the same write: ABORT wins, START is discarded.
- CLR_DONE clears done and done_irq. If CLR_DONE and START arrive together, START's clear applies; the result is the same.
- Asserting axi_rst mid-run drops ising_rstn to 0 asynchronously; the run is lost.
- spin_in is never used unsynchronised.

Decomposition:
- Shared package ising_ctrl_pkg:
  - register index constants (REG_CTRL..REG_ELAPSED);
  - CTRL bit positions;
  - state encoding constants.
- One sub-module: spin_sync, an NUM_SPINS-wide, SYNC_STAGES-deep synchroniser with async active-high reset.
- Counters and FSM stay in ising_run_ctrl.

Test Plan:
1. Reset: assert axi_rst for 3 cycles -> ising_rstn=0, rdata=0 for indices 0..4, done_irq=0.
2. Basic run: RUN_CYCLES=10, SETTLE_CYCLES=4, spin_in=0xA5A5_0F0F, write START at edge N.
   - ising_rstn 0 for edges N+1..N+4 and 1 for exactly 10+2 cycles.
   - Then done_irq=1, SAMPLE=0xA5A5_0F0F, ELAPSED=10.
3. Zero length: RUN_CYCLES=0 -> one RUN cycle, ELAPSED=1, done set.
4. Abort mid-RUN: ABORT on the 5th RUN cycle -> next edge ising_rstn=0, STATUS=0b100, SAMPLE keeps its prior value, done_irq=0.
5. Collisions:
   - START while busy, plus a RUN_CYCLES write of 99 during RUN -> run length unchanged; read-back stays at the original value.
   - START+ABORT together from IDLE -> stays IDLE, aborted=0.
6. spin_in change in the final CAPTURE cycle: toggle bit0 one cycle before capture -> SAMPLE bit0 shows the pre-toggle value. Then CLR_DONE -> done_irq=0.
